// File: rtl/limn2600_memarb_pkg.sv
// limn2600_memarb_pkg
//   Shared definitions for the limn2600 memory arbiter: the read-source tag
//   that travels through the tag FIFO, the 32-bit size code, the default tag
//   depth, and the registered command records driven to the scheduler.
package limn2600_memarb_pkg;

   // Read source, stored per outstanding read so completions can be routed.
   typedef enum logic {
      SRC_IF = 1'b0,
      SRC_D  = 1'b1
   } src_e;

   localparam logic [1:0] SIZE_32           = 2'b11;
   localparam int         DEFAULT_TAG_DEPTH = 8;

   // Registered read command towards the scheduler.
   typedef struct packed {
      logic        en;
      logic [31:0] addr;
      logic [1:0]  size;
   } rd_cmd_t;

   // Registered write command towards the scheduler.
   typedef struct packed {
      logic        en;
      logic [31:0] addr;
      logic [31:0] value;
      logic [1:0]  size;
   } wr_cmd_t;

endpackage

// File: rtl/limn2600_mem_arbiter_if.sv
// limn2600_mem_arbiter_if
//   Bundles every handshake/bus signal of the memory arbiter: the
//   instruction-fetch read port (if_*), the data read/write port (d_*), the
//   shared pipeline flush, and the scheduler command/completion port (m_*).
//   Modports:
//     slave  - the arbiter itself (takes requests, drives grants and m_* commands)
//     master - the surrounding system (CPU ports and scheduler model)
interface limn2600_mem_arbiter_if;

   // Instruction-fetch port
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic [31:0] if_rdata;
   logic        if_rvalid;

   // Data port
   logic        d_rd_req;
   logic        d_wr_req;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [1:0]  d_size;
   logic        d_gnt;
   logic [31:0] d_rdata;
   logic        d_rvalid;

   // Pipeline flush shared with the scheduler
   logic        flush;

   // Scheduler port
   logic [31:0] m_rd_addr;
   logic [1:0]  m_rd_size;
   logic        m_rd_en;
   logic [31:0] m_wr_addr;
   logic [31:0] m_wr_value;
   logic [1:0]  m_wr_size;
   logic        m_wr_en;
   logic [31:0] m_rd_value;
   logic        m_rd_rdy;
   logic        m_full;

   modport slave (
      input  if_req, if_addr,
      input  d_rd_req, d_wr_req, d_addr, d_wdata, d_size,
      input  flush,
      input  m_rd_value, m_rd_rdy, m_full,
      output if_gnt, if_rdata, if_rvalid,
      output d_gnt, d_rdata, d_rvalid,
      output m_rd_addr, m_rd_size, m_rd_en,
      output m_wr_addr, m_wr_value, m_wr_size, m_wr_en
   );

   modport master (
      output if_req, if_addr,
      output d_rd_req, d_wr_req, d_addr, d_wdata, d_size,
      output flush,
      output m_rd_value, m_rd_rdy, m_full,
      input  if_gnt, if_rdata, if_rvalid,
      input  d_gnt, d_rdata, d_rvalid,
      input  m_rd_addr, m_rd_size, m_rd_en,
      input  m_wr_addr, m_wr_value, m_wr_size, m_wr_en
   );

endinterface

// File: rtl/limn2600_mem_arbiter_tagfifo.sv
// limn2600_mem_arbiter_tagfifo
//   FIFO of read sources, one entry per outstanding read, in issue order.
//   Ports:
//     clk, rst  - clock and synchronous active-high reset
//     push, din - record the source of a newly granted read
//     pop       - a read completed; ignored while empty
//     dout      - source of the oldest outstanding read (valid when count != 0)
//     count     - number of outstanding reads, log2(TAG_DEPTH)+1 bits
//     clear     - drop every outstanding entry (pipeline flush)
//   TAG_DEPTH must be a power of two so the pointers wrap naturally.
module limn2600_mem_arbiter_tagfifo
   import limn2600_memarb_pkg::*;
#(
   parameter int TAG_DEPTH = DEFAULT_TAG_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  src_e                       din,
   output src_e                       dout,
   output logic [$clog2(TAG_DEPTH):0] count,
   input  logic                       clear
);

   localparam int            AW      = $clog2(TAG_DEPTH);
   localparam int            CW      = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(TAG_DEPTH);

   src_e          mem_q [TAG_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push;
   logic          do_pop;

   // NOTE: every variable written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      do_push  = push && (count_q != DEPTH_C);
      do_pop   = pop && (count_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         // Push and pop together leave the count unchanged.
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; the pointers and count
   // alone decide which entries are meaningful.
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/limn2600_mem_arbiter.sv
// limn2600_mem_arbiter
//   Merges the instruction-fetch and data ports onto the scheduler's single
//   read and single write command channel. Grants are combinational; the
//   accepted command is registered and presented on m_* one cycle later for
//   exactly one cycle. Each read grant records its source in a tag FIFO so
//   completions (m_rd_rdy/m_rd_value) are routed back in order, one cycle
//   after they arrive.
//   Ports:
//     clk - clock, rising edge
//     rst - synchronous active-high reset
//     bus - limn2600_mem_arbiter_if.slave (if_*, d_*, flush, m_*)
//   Parameter:
//     TAG_DEPTH - maximum outstanding reads (power of two)
//   Configuration macro:
//     MEMARB_RR_EN - when defined, simultaneous IF/D reads are arbitrated
//                    round-robin (pointer starts at IF); otherwise the data
//                    port always wins.
module limn2600_mem_arbiter
   import limn2600_memarb_pkg::*;
#(
   parameter int TAG_DEPTH = DEFAULT_TAG_DEPTH
) (
   input logic                   clk,
   input logic                   rst,
   limn2600_mem_arbiter_if.slave bus
);

   localparam int            CW      = $clog2(TAG_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(TAG_DEPTH);

   logic [CW-1:0] tag_count;
   src_e          tag_dout;
   src_e          tag_din;
   logic          tag_push;

   logic          can_issue;
   logic          tag_room;
   logic          rd_contend;
   logic          rd_grant_if;
   logic          rd_grant_d;
   logic          wr_grant;
   logic          resp_ok;

   rd_cmd_t       rd_cmd_q, rd_cmd_d;
   wr_cmd_t       wr_cmd_q, wr_cmd_d;
   logic          if_rvalid_q, if_rvalid_d;
   logic          d_rvalid_q, d_rvalid_d;
   logic [31:0]   if_rdata_q, if_rdata_d;
   logic [31:0]   d_rdata_q, d_rdata_d;

`ifdef MEMARB_RR_EN
   src_e          rr_q, rr_d;
`endif

   // Grant logic. Reads need a free tag slot, judged on the registered count
   // only: a completion in the same cycle does not open a slot until the edge.
   always_comb begin
      can_issue   = !rst && !bus.flush && !bus.m_full;
      tag_room    = tag_count < DEPTH_C;
      rd_contend  = bus.if_req && bus.d_rd_req;
      wr_grant    = can_issue && bus.d_wr_req;
      rd_grant_if = 1'b0;
      rd_grant_d  = 1'b0;
      if (can_issue && tag_room) begin
         if (rd_contend) begin
`ifdef MEMARB_RR_EN
            if (rr_q == SRC_IF) rd_grant_if = 1'b1;
            else                rd_grant_d  = 1'b1;
`else
            rd_grant_d = 1'b1;
`endif
         end else begin
            rd_grant_if = bus.if_req;
            rd_grant_d  = bus.d_rd_req;
         end
      end
   end

`ifdef MEMARB_RR_EN
   // The pointer moves only when both sources competed and one was served.
   always_comb begin
      rr_d = rr_q;
      if (rd_contend && (rd_grant_if || rd_grant_d))
         rr_d = (rr_q == SRC_IF) ? SRC_D : SRC_IF;
   end
`endif

   assign bus.if_gnt = rd_grant_if;
   assign bus.d_gnt  = rd_grant_d || wr_grant;

   assign tag_push = rd_grant_if || rd_grant_d;
   assign tag_din  = rd_grant_d ? SRC_D : SRC_IF;

   // Command registers: address/data hold their last value, enables pulse.
   always_comb begin
      rd_cmd_d    = rd_cmd_q;
      rd_cmd_d.en = 1'b0;
      if (rd_grant_d) begin
         rd_cmd_d.en   = 1'b1;
         rd_cmd_d.addr = bus.d_addr;
         rd_cmd_d.size = bus.d_size;
      end else if (rd_grant_if) begin
         rd_cmd_d.en   = 1'b1;
         rd_cmd_d.addr = bus.if_addr;
         rd_cmd_d.size = SIZE_32;
      end

      wr_cmd_d    = wr_cmd_q;
      wr_cmd_d.en = 1'b0;
      if (wr_grant) begin
         wr_cmd_d.en    = 1'b1;
         wr_cmd_d.addr  = bus.d_addr;
         wr_cmd_d.value = bus.d_wdata;
         wr_cmd_d.size  = bus.d_size;
      end
   end

   // Completion routing. A completion with nothing outstanding, or one that
   // lands in a flush cycle, is dropped.
   always_comb begin
      resp_ok     = bus.m_rd_rdy && (tag_count != '0) && !bus.flush;
      if_rvalid_d = resp_ok && (tag_dout == SRC_IF);
      d_rvalid_d  = resp_ok && (tag_dout == SRC_D);
      if_rdata_d  = if_rvalid_d ? bus.m_rd_value : if_rdata_q;
      d_rdata_d   = d_rvalid_d  ? bus.m_rd_value : d_rdata_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_cmd_q    <= '0;
         wr_cmd_q    <= '0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
`ifdef MEMARB_RR_EN
         rr_q        <= SRC_IF;
`endif
      end else begin
         rd_cmd_q    <= rd_cmd_d;
         wr_cmd_q    <= wr_cmd_d;
         if_rvalid_q <= if_rvalid_d;
         d_rvalid_q  <= d_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
`ifdef MEMARB_RR_EN
         rr_q        <= rr_d;
`endif
      end
   end

   limn2600_mem_arbiter_tagfifo #(
      .TAG_DEPTH (TAG_DEPTH)
   ) u_tagfifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tag_push),
      .pop   (bus.m_rd_rdy),
      .din   (tag_din),
      .dout  (tag_dout),
      .count (tag_count),
      .clear (bus.flush)
   );

   assign bus.m_rd_en    = rd_cmd_q.en;
   assign bus.m_rd_addr  = rd_cmd_q.addr;
   assign bus.m_rd_size  = rd_cmd_q.size;
   assign bus.m_wr_en    = wr_cmd_q.en;
   assign bus.m_wr_addr  = wr_cmd_q.addr;
   assign bus.m_wr_value = wr_cmd_q.value;
   assign bus.m_wr_size  = wr_cmd_q.size;
   assign bus.if_rvalid  = if_rvalid_q;
   assign bus.if_rdata   = if_rdata_q;
   assign bus.d_rvalid   = d_rvalid_q;
   assign bus.d_rdata    = d_rdata_q;

endmodule
